subleq_ctrl_fsm: RTL and testbench

Sequencing controller for the SUBLEQ CPU. It drives the unified ABC memory: it fetches the A/B/C operand triple at `pc`, reads `mem[A]` and `mem[B]`, and writes `mem[B] - mem[A]` back to `mem[B]`. It then sets `pc` to C when the result is ≤ 0 (signed), and to `pc + 3` otherwise. It sits directly upstream of the memory block: it produces every address and enable that block consumes, and it consumes the memory's registered read data.

---
 rtl/subleq_pkg.sv | 23 ++
 rtl/subleq_ctrl_fsm_alu.sv | 15 +
 rtl/subleq_ctrl_fsm.sv | 115 +++++++++++
 tb/tb_subleq_ctrl_fsm.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ sequencing controller: datapath width,
// default fall-through stride, FSM state encoding and the <=0 test.
package subleq_pkg;

    localparam int SUBLEQ_W = 64;

    localparam logic [SUBLEQ_W-1:0] SUBLEQ_STRIDE = 64'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        LOAD   = 3'd3,
        EXEC   = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Signed "less than or equal to zero" on a two's complement word.
    function automatic logic is_leq(input logic [SUBLEQ_W-1:0] value);
        return value[SUBLEQ_W-1] | (value == '0);
    endfunction

endpackage

// File: rtl/subleq_ctrl_fsm_alu.sv
// Combinational subtract-and-test for the EXEC cycle: diff = mem_b - mem_a
// (wrapping), leq flags a signed result <= 0.
module subleq_alu
    import subleq_pkg::*;
(
    input  logic [SUBLEQ_W-1:0] mem_a,
    input  logic [SUBLEQ_W-1:0] mem_b,
    output logic [SUBLEQ_W-1:0] diff,
    output logic                leq
);

    assign diff = mem_b - mem_a;
    assign leq  = is_leq(diff);

endmodule

// File: rtl/subleq_ctrl_fsm.sv
// SUBLEQ sequencing controller. Runs a 4-cycle loop
// FETCH -> DECODE -> LOAD -> EXEC against a memory with registered reads.
// Optional feature macro: SUBLEQ_HALT_EN (a taken branch to a negative C
// retires the instruction and parks the FSM in HALT until rst).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for run; no strobes
// FETCH  | read_en_abc, operand triple addressed by pc
// DECODE | triple arrives; latch addr_a, addr_b, c_reg
// LOAD   | read_en_a / read_en_b for mem[addr_a], mem[addr_b]
// EXEC   | write diff to mem[addr_b], update pc, retire
// HALT   | sticky stop (only with SUBLEQ_HALT_EN); no strobes
module subleq_ctrl_fsm
    import subleq_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'd0,
    parameter logic [63:0] STRIDE   = SUBLEQ_STRIDE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [63:0] data_out_a,
    input  logic [63:0] data_out_b,
    input  logic [63:0] data_out_c,
    input  logic [63:0] data_out_mem_a,
    input  logic [63:0] data_out_mem_b,
    output logic [63:0] pc,
    output logic [63:0] addr_a,
    output logic [63:0] addr_b,
    output logic [63:0] data_in,
    output logic        write_en_b,
    output logic        read_en_abc,
    output logic        read_en_a,
    output logic        read_en_b,
    output logic        halted,
    output logic [31:0] instr_count
);

    state_t      state;
    logic [63:0] c_reg;
    logic [63:0] diff;
    logic        leq;
    logic        halt_now;

    subleq_alu u_alu (
        .mem_a (data_out_mem_a),
        .mem_b (data_out_mem_b),
        .diff  (diff),
        .leq   (leq)
    );

`ifdef SUBLEQ_HALT_EN
    assign halt_now = leq & c_reg[63];
    assign halted   = (state == HALT);
`else
    assign halt_now = 1'b0;
    assign halted   = 1'b0;
`endif

    // Strobes decode straight from the state register so each is exactly one
    // cycle wide; the write is gated by rst so an aborted EXEC never commits.
    assign read_en_abc = (state == FETCH);
    assign read_en_a   = (state == LOAD);
    assign read_en_b   = (state == LOAD);
    assign write_en_b  = (state == EXEC) & ~rst;
    assign data_in     = (state == EXEC) ? diff : '0;

    // Instruction sequencer: state, operand latches, pc and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= PC_RESET;
            addr_a      <= '0;
            addr_b      <= '0;
            c_reg       <= '0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) state <= FETCH;
                end
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    addr_a <= data_out_a;
                    addr_b <= data_out_b;
                    c_reg  <= data_out_c;
                    state  <= LOAD;
                end
                LOAD: begin
                    state <= EXEC;
                end
                EXEC: begin
                    instr_count <= instr_count + 32'd1;
                    if (halt_now) begin
                        // pc is left pointing at the halting instruction.
                        state <= HALT;
                    end else begin
                        pc    <= leq ? c_reg : pc + STRIDE;
                        state <= run ? FETCH : IDLE;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_ctrl_fsm.sv
// Scoreboard bench for subleq_ctrl_fsm with a small behavioural memory.
// Stimulus pushes the expected write/pc/count per instruction; a monitor pops
// and compares whenever the DUT strobes write_en_b.
module tb_subleq_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic        run;
    logic [63:0] data_out_a, data_out_b, data_out_c;
    logic [63:0] data_out_mem_a, data_out_mem_b;
    logic [63:0] pc, addr_a, addr_b, data_in;
    logic        write_en_b, read_en_abc, read_en_a, read_en_b, halted;
    logic [31:0] instr_count;

    subleq_ctrl_fsm #(.PC_RESET(64'd0), .STRIDE(64'd3)) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .data_out_a     (data_out_a),
        .data_out_b     (data_out_b),
        .data_out_c     (data_out_c),
        .data_out_mem_a (data_out_mem_a),
        .data_out_mem_b (data_out_mem_b),
        .pc             (pc),
        .addr_a         (addr_a),
        .addr_b         (addr_b),
        .data_in        (data_in),
        .write_en_b     (write_en_b),
        .read_en_abc    (read_en_abc),
        .read_en_a      (read_en_a),
        .read_en_b      (read_en_b),
        .halted         (halted),
        .instr_count    (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: 64 words, registered reads, bench back-door load port.
    logic [63:0] mem [0:63];
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [63:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (write_en_b) mem[addr_b[5:0]] <= data_in;
        if (read_en_abc) begin
            data_out_a <= mem[pc[5:0]];
            data_out_b <= mem[pc[5:0] + 6'd1];
            data_out_c <= mem[pc[5:0] + 6'd2];
        end
        if (read_en_a) data_out_mem_a <= mem[addr_a[5:0]];
        if (read_en_b) data_out_mem_b <= mem[addr_b[5:0]];
    end

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] npc;
        logic [31:0] cnt;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_busy = 0;
    int   cyc = 0;
    int   last_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (write_en_b) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {63'd0, write_en_b}, 64'd0);
                end else begin
                    mon_busy = 1;
                    e = sb.pop_front();
                    chk("write_addr", addr_b, e.addr);
                    chk("write_data", data_in, e.data);
                    chk("fetch_during_write", {63'd0, read_en_abc}, 64'd0);
                    if (e.gap != 0) chk("throughput_gap", 64'(cyc - last_wr), 64'(e.gap));
                    last_wr = cyc;
                    @(negedge clk);
                    chk("next_pc", pc, e.npc);
                    chk("instr_count", {32'd0, instr_count}, {32'd0, e.cnt});
                    mon_busy = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic load(input int a, input logic [63:0] d);
        ld_en   = 1'b1;
        ld_addr = a[5:0];
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic reset_and_clear();
        rst = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 64; i++) load(i, 64'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((sb.size() != 0 || mon_busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {63'd0, (sb.size() == 0 && !mon_busy)}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // One instruction at pc 0: triple (a,b,c), mem[a]=ma, then mem[b]=mb.
    task automatic single(input string nm, input int a, input int b, input logic [63:0] c,
                          input logic [63:0] ma, input logic [63:0] mb,
                          input logic [63:0] exp_data, input logic [63:0] exp_pc);
        exp_t e;
        reset_and_clear();
        load(0, 64'(a));
        load(1, 64'(b));
        load(2, c);
        load(a, ma);
        load(b, mb);
        release_reset();
        chk({nm, "_reset_pc"}, pc, 64'd0);
        chk({nm, "_reset_cnt"}, {32'd0, instr_count}, 64'd0);
        e.addr = 64'(b); e.data = exp_data; e.npc = exp_pc; e.cnt = 32'd1; e.gap = 0;
        sb.push_back(e);
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        chk({nm, "_first_fetch"}, {63'd0, read_en_abc}, 64'd1);
        wait_drain({nm, "_drain"});
        chk({nm, "_mem_b"}, mem[b], exp_data);
        chk({nm, "_pc_idle"}, pc, exp_pc);
    endtask

    initial begin
        exp_t e;
        int   n;
        int   strobes;
        rst   = 1'b1;
        run   = 1'b0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        @(posedge clk);
        #1;

        // Reset state of every output.
        reset_and_clear();
        release_reset();
        chk("rst_pc", pc, 64'd0);
        chk("rst_addr_a", addr_a, 64'd0);
        chk("rst_addr_b", addr_b, 64'd0);
        chk("rst_data_in", data_in, 64'd0);
        chk("rst_strobes", {60'd0, write_en_b, read_en_abc, read_en_a, read_en_b}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_count", {32'd0, instr_count}, 64'd0);

        single("neg_taken", 9, 10, 64'd6, 64'd5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'd6);
        single("pos_fall", 9, 10, 64'd6, 64'd2, 64'd7, 64'd5, 64'd3);
        single("a_eq_b", 12, 12, 64'd40, 64'h42, 64'h42, 64'd0, 64'd40);
        single("wrap", 9, 10, 64'd6, 64'd1, 64'h8000_0000_0000_0000,
               64'h7FFF_FFFF_FFFF_FFFF, 64'd3);
`ifndef SUBLEQ_HALT_EN
        single("neg_c", 9, 10, 64'hFFFF_FFFF_FFFF_FFF0, 64'd1, 64'd1, 64'd0,
               64'hFFFF_FFFF_FFFF_FFF0);
        chk("neg_c_halted", {63'd0, halted}, 64'd0);
`endif

        // Back-to-back run with self-modifying code; run drops mid-instruction 3.
        reset_and_clear();
        load(0, 64'd30); load(1, 64'd31); load(2, 64'd3);
        load(3, 64'd33); load(4, 64'd7);  load(5, 64'd6);
        load(6, 64'd30); load(7, 64'd50); load(8, 64'd9);
        load(30, 64'd1); load(31, 64'd5); load(33, 64'd10); load(40, 64'd1);
        release_reset();
        e.addr = 64'd31; e.data = 64'd4;  e.npc = 64'd3; e.cnt = 32'd1; e.gap = 0; sb.push_back(e);
        e.addr = 64'd7;  e.data = 64'd40; e.npc = 64'd6; e.cnt = 32'd2; e.gap = 4; sb.push_back(e);
        e.addr = 64'd40; e.data = 64'd0;  e.npc = 64'd9; e.cnt = 32'd3; e.gap = 4; sb.push_back(e);
        run = 1'b1;
        n = 0;
        while (sb.size() > 1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        run = 1'b0;
        wait_drain("chain_drain");
        chk("chain_mem7", mem[7], 64'd40);
        chk("chain_mem40", mem[40], 64'd0);
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            strobes += int'(read_en_abc) + int'(read_en_a) + int'(write_en_b);
        end
        chk("chain_idle_strobes", 64'(strobes), 64'd0);
        chk("chain_idle_pc", pc, 64'd9);

        // rst during EXEC aborts the instruction and suppresses the write.
        reset_and_clear();
        load(0, 64'd9); load(1, 64'd10); load(2, 64'd6);
        load(9, 64'd2); load(10, 64'd7);
        release_reset();
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        n = 0;
        while (!read_en_a && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_load", {63'd0, read_en_a}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_no_write", {63'd0, write_en_b}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_pc", pc, 64'd0);
        chk("abort_count", {32'd0, instr_count}, 64'd0);
        chk("abort_mem", mem[10], 64'd7);

`ifdef SUBLEQ_HALT_EN
        // Taken branch to negative C halts; strobes stay low until rst.
        reset_and_clear();
        load(0, 64'd9); load(1, 64'd10); load(2, 64'hFFFF_FFFF_FFFF_FFFF);
        load(9, 64'd1); load(10, 64'd1);
        release_reset();
        e.addr = 64'd10; e.data = 64'd0; e.npc = 64'd0; e.cnt = 32'd1; e.gap = 0;
        sb.push_back(e);
        run = 1'b1;
        wait_drain("halt_drain");
        chk("halt_halted", {63'd0, halted}, 64'd1);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            strobes += int'(read_en_abc) + int'(read_en_a) + int'(read_en_b) + int'(write_en_b);
        end
        chk("halt_no_strobes", 64'(strobes), 64'd0);
        chk("halt_pc", pc, 64'd0);
        run = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("halt_cleared", {63'd0, halted}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
